// File: rtl/haz_pkg.sv
// Shared forward-select encodings and sizing helpers for the hazard scoreboard.
package haz_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_EX  = 2'b11
    } fwd_sel_e;

    // Register index width; a one-register file still needs a 1-bit index.
    function automatic int unsigned idx_w(input int unsigned nreg);
        return (nreg > 1) ? 32'($clog2(nreg)) : 32'd1;
    endfunction

    function automatic int unsigned busy_w(input int unsigned nreg);
        return 32'($clog2(nreg)) + 32'd1;
    endfunction

    function automatic int unsigned lat_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/haz_sb_entry.sv
// One architectural register's scoreboard slot: pending bit, variable-latency
// flag and fixed-latency countdown.
module haz_sb_entry #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_issue,
    input  logic [CNT_W-1:0] i_issue_lat,
    input  logic             i_done,
    output logic             o_pending,
    output logic             o_long,
    output logic             o_pending_nxt
);

    logic             r_pending;
    logic             r_long;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pending_nxt;
    logic             w_long_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Issue re-arms the slot and outranks both completion and countdown.
    always_comb begin
        w_pending_nxt = r_pending;
        w_long_nxt    = r_long;
        w_cnt_nxt     = r_cnt;
        if (i_issue) begin
            w_pending_nxt = 1'b1;
            if (i_issue_lat != '0) begin
                w_long_nxt = 1'b0;
                w_cnt_nxt  = i_issue_lat;
            end else begin
                w_long_nxt = 1'b1;
                w_cnt_nxt  = '0;
            end
        end else if (i_done && (r_pending || r_long)) begin
            w_pending_nxt = 1'b0;
            w_long_nxt    = 1'b0;
            w_cnt_nxt     = '0;
        end else if (r_pending && !r_long) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                w_pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pending <= 1'b0;
            r_long    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_long    <= w_long_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_pending     = r_pending;
    assign o_long        = r_long;
    assign o_pending_nxt = w_pending_nxt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard/forwarding unit beside ID: issue stall and per-port forward selects.
// Optional stall statistics counters enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
    import haz_pkg::*;
#(
    parameter  int unsigned NREG  = 32,
    parameter  int unsigned NSRC  = 2,
    parameter  int unsigned CNT_W = 4,
    localparam int unsigned RW    = idx_w(NREG),
    localparam int unsigned BW    = busy_w(NREG)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_issue_valid,
    input  logic [RW-1:0]       i_issue_dst,
    input  logic [CNT_W-1:0]    i_issue_lat,
    input  logic                i_done_valid,
    input  logic [RW-1:0]       i_done_dst,
    input  logic [NSRC-1:0]     i_src_valid,
    input  logic [NSRC-1:0]     i_src_need,
    input  logic [NSRC*RW-1:0]  i_src_reg,
    input  logic [RW-1:0]       i_ex_dst,
    input  logic [RW-1:0]       i_mem_dst,
    input  logic [RW-1:0]       i_wb_dst,
    input  logic                i_ex_rdy,
    input  logic                i_mem_rdy,
    input  logic                i_wb_rdy,
    output logic                o_stall,
    output logic [NSRC*2-1:0]   o_fwd_sel,
    output logic [BW-1:0]       o_busy_count
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         o_stall_raw_cycles,
    output logic [31:0]         o_stall_waw_cycles
`endif
);

    logic [NREG-1:0] w_pending;
    logic [NREG-1:0] w_long;
    logic [NREG-1:0] w_pending_nxt;
    logic [NSRC-1:0] w_raw;
    logic            w_raw_any;
    logic            w_waw;
    logic            w_accept;
    fwd_sel_e        w_sel [NSRC];
    logic [BW-1:0]   w_busy_nxt;
    logic [BW-1:0]   r_busy_count;

    assign w_accept = i_issue_valid && !o_stall;

    // Register 0 is hardwired zero and never tracked.
    assign w_pending[0]     = 1'b0;
    assign w_long[0]        = 1'b0;
    assign w_pending_nxt[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        haz_sb_entry #(
            .CNT_W(CNT_W)
        ) u_entry (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_issue      (w_accept && (i_issue_dst == RW'(i))),
            .i_issue_lat  (i_issue_lat),
            .i_done       (i_done_valid && (i_done_dst == RW'(i))),
            .o_pending    (w_pending[i]),
            .o_long       (w_long[i]),
            .o_pending_nxt(w_pending_nxt[i])
        );
    end

    // Per-port forward priority EX > MEM > WB; a RAW hazard is a needed operand with no live source.
    for (genvar p = 0; p < NSRC; p++) begin : g_port
        logic [RW-1:0] w_reg;
        logic          w_act;
        logic          w_hit_ex;
        logic          w_hit_mem;
        logic          w_hit_wb;

        assign w_reg     = i_src_reg[p*RW +: RW];
        assign w_act     = i_src_valid[p] && (w_reg != '0);
        assign w_hit_ex  = w_act && i_ex_rdy  && (i_ex_dst  == w_reg);
        assign w_hit_mem = w_act && i_mem_rdy && (i_mem_dst == w_reg);
        assign w_hit_wb  = w_act && i_wb_rdy  && (i_wb_dst  == w_reg);

        assign w_sel[p] = i_reset   ? FWD_RF  :
                          w_hit_ex  ? FWD_EX  :
                          w_hit_mem ? FWD_MEM :
                          w_hit_wb  ? FWD_WB  : FWD_RF;

        assign w_raw[p] = i_issue_valid && w_act && i_src_need[p] && w_pending[w_reg]
                          && !(w_hit_ex || w_hit_mem || w_hit_wb);

        assign o_fwd_sel[p*2 +: 2] = w_sel[p];
    end

    assign w_raw_any = |w_raw;
    assign w_waw     = i_issue_valid && (i_issue_dst != '0)
                       && w_pending[i_issue_dst] && w_long[i_issue_dst];
    assign o_stall   = !i_reset && (w_raw_any || w_waw);

    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_busy_nxt = w_busy_nxt + BW'(w_pending_nxt[i]);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy_count <= '0;
        end else begin
            r_busy_count <= w_busy_nxt;
        end
    end

    assign o_busy_count = i_reset ? '0 : r_busy_count;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] r_raw_cycles;
    logic [31:0] r_waw_cycles;

    // Saturating counts of cycles each hazard class blocked issue.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_raw_cycles <= '0;
            r_waw_cycles <= '0;
        end else begin
            if (w_raw_any && (r_raw_cycles != '1)) begin
                r_raw_cycles <= r_raw_cycles + 32'd1;
            end
            if (w_waw && (r_waw_cycles != '1)) begin
                r_waw_cycles <= r_waw_cycles + 32'd1;
            end
        end
    end

    assign o_stall_raw_cycles = r_raw_cycles;
    assign o_stall_waw_cycles = r_waw_cycles;
`else
    // Stall statistics compiled out.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random traffic,
// predicted by a register-lifetime model and checked by a separate monitor.
module tb_hazard_scoreboard;

    localparam int unsigned NREG  = 32;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned RW    = 5;
    localparam int unsigned BW    = 6;

    typedef struct {
        bit                 rst;
        bit                 iv;
        bit [RW-1:0]        idst;
        bit [CNT_W-1:0]     ilat;
        bit                 dv;
        bit [RW-1:0]        ddst;
        bit [NSRC-1:0]      sv;
        bit [NSRC-1:0]      sn;
        bit [NSRC*RW-1:0]   srs;
        bit [RW-1:0]        exd, memd, wbd;
        bit                 exr, memr, wbr;
    } stim_t;

    typedef struct {
        int                 cyc;
        bit                 chk_stats;
        bit                 stall;
        bit [NSRC*2-1:0]    fwd;
        bit [BW-1:0]        busy;
        bit [31:0]          rawc;
        bit [31:0]          wawc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                issue_valid;
    logic [RW-1:0]       issue_dst;
    logic [CNT_W-1:0]    issue_lat;
    logic                done_valid;
    logic [RW-1:0]       done_dst;
    logic [NSRC-1:0]     src_valid;
    logic [NSRC-1:0]     src_need;
    logic [NSRC*RW-1:0]  src_reg;
    logic [RW-1:0]       ex_dst, mem_dst, wb_dst;
    logic                ex_rdy, mem_rdy, wb_rdy;
    logic                stall;
    logic [NSRC*2-1:0]   fwd_sel;
    logic [BW-1:0]       busy_count;
    logic [31:0]         raw_cyc;
    logic [31:0]         waw_cyc;

    hazard_scoreboard #(
        .NREG (NREG),
        .NSRC (NSRC),
        .CNT_W(CNT_W)
    ) dut (
        .i_clock           (clk),
        .i_reset           (reset),
        .i_issue_valid     (issue_valid),
        .i_issue_dst       (issue_dst),
        .i_issue_lat       (issue_lat),
        .i_done_valid      (done_valid),
        .i_done_dst        (done_dst),
        .i_src_valid       (src_valid),
        .i_src_need        (src_need),
        .i_src_reg         (src_reg),
        .i_ex_dst          (ex_dst),
        .i_mem_dst         (mem_dst),
        .i_wb_dst          (wb_dst),
        .i_ex_rdy          (ex_rdy),
        .i_mem_rdy         (mem_rdy),
        .i_wb_rdy          (wb_rdy),
        .o_stall           (stall),
        .o_fwd_sel         (fwd_sel),
        .o_busy_count      (busy_count)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .o_stall_raw_cycles(raw_cyc),
        .o_stall_waw_cycles(waw_cyc)
`endif
    );

`ifndef HAZARD_SCOREBOARD_STATS_EN
    assign raw_cyc = '0;
    assign waw_cyc = '0;
`endif

    // Reference model: remaining pending cycles of fixed-latency writes, plus
    // an open-ended flag for writes awaiting done.
    int          rem [NREG];
    bit          lng [NREG];
    bit [31:0]   m_raw = 0;
    bit [31:0]   m_waw = 0;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    stim_t       prev;
    exp_t        prev_e;
    bit          prev_raw, prev_waw;
    bit          have_prev = 0;

    function automatic bit pend(input bit [RW-1:0] r);
        return (rem[r] > 0) || lng[r];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit [NSRC*RW-1:0] srcs(input bit [RW-1:0] r0, input bit [RW-1:0] r1);
        return {r1, r0};
    endfunction

    task automatic predict(input stim_t s, output exp_t e, output bit raw_any, output bit waw);
        int n;
        e = '{default: 0};
        raw_any = 0;
        waw = 0;
        e.cyc = cyc;
        e.chk_stats = !s.rst;
        e.rawc = m_raw;
        e.wawc = m_waw;
        if (s.rst) return;
        n = 0;
        for (int r = 0; r < NREG; r++) if (pend(RW'(r))) n++;
        e.busy = BW'(n);
        for (int p = 0; p < NSRC; p++) begin
            bit [RW-1:0] r;
            bit [1:0]    sel;
            bit          act;
            r   = s.srs[p*RW +: RW];
            act = s.sv[p] && (r != 0);
            sel = 2'b00;
            if (act) begin
                if (s.exr && s.exd == r)        sel = 2'b11;
                else if (s.memr && s.memd == r) sel = 2'b01;
                else if (s.wbr && s.wbd == r)   sel = 2'b10;
            end
            e.fwd[p*2 +: 2] = sel;
            if (s.iv && act && s.sn[p] && pend(r) && sel == 2'b00) raw_any = 1;
        end
        waw = s.iv && (s.idst != 0) && lng[s.idst];
        e.stall = raw_any || waw;
    endtask

    task automatic step_model(input stim_t s, input bit stl, input bit raw_any, input bit waw);
        if (s.rst) begin
            for (int r = 0; r < NREG; r++) begin
                rem[r] = 0;
                lng[r] = 0;
            end
            m_raw = 0;
            m_waw = 0;
            return;
        end
        for (int r = 0; r < NREG; r++) if (!lng[r] && rem[r] > 0) rem[r]--;
        if (s.dv) begin
            rem[s.ddst] = 0;
            lng[s.ddst] = 0;
        end
        if (s.iv && !stl && s.idst != 0) begin
            rem[s.idst] = int'(s.ilat);
            lng[s.idst] = (s.ilat == 0);
        end
        if (raw_any && m_raw != 32'hFFFF_FFFF) m_raw++;
        if (waw && m_waw != 32'hFFFF_FFFF) m_waw++;
    endtask

    task automatic cycle(input stim_t s);
        exp_t e;
        bit   ra, wa;
        @(posedge clk);
        if (have_prev) step_model(prev, prev_e.stall, prev_raw, prev_waw);
        #1;
        cyc++;
        reset       = s.rst;
        issue_valid = s.iv;
        issue_dst   = s.idst;
        issue_lat   = s.ilat;
        done_valid  = s.dv;
        done_dst    = s.ddst;
        src_valid   = s.sv;
        src_need    = s.sn;
        src_reg     = s.srs;
        ex_dst      = s.exd;
        mem_dst     = s.memd;
        wb_dst      = s.wbd;
        ex_rdy      = s.exr;
        mem_rdy     = s.memr;
        wb_rdy      = s.wbr;
        predict(s, e, ra, wa);
        exp_q.push_back(e);
        prev      = s;
        prev_e    = e;
        prev_raw  = ra;
        prev_waw  = wa;
        have_prev = 1;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                chk("stall", me.cyc, 32'(stall), 32'(me.stall));
                chk("fwd_sel", me.cyc, 32'(fwd_sel), 32'(me.fwd));
                chk("busy_count", me.cyc, 32'(busy_count), 32'(me.busy));
`ifdef HAZARD_SCOREBOARD_STATS_EN
                if (me.chk_stats) begin
                    chk("stall_raw_cycles", me.cyc, raw_cyc, me.rawc);
                    chk("stall_waw_cycles", me.cyc, waw_cyc, me.wawc);
                end
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        for (int r = 0; r < NREG; r++) begin
            rem[r] = 0;
            lng[r] = 0;
        end
        s = idle(); s.rst = 1;
        cycle(s); cycle(s);
        s = idle(); cycle(s);

        // Fixed latency 3 blocks a needed read for 3 cycles.
        s = idle(); s.iv = 1; s.idst = 5; s.ilat = 3; cycle(s);
        s = idle(); s.iv = 1; s.sv = 2'b01; s.sn = 2'b01; s.srs = srcs(5, 0);
        repeat (5) cycle(s);

        // Forwarding from MEM, then EX taking priority.
        s = idle(); s.iv = 1; s.idst = 5; s.ilat = 3; cycle(s);
        s = idle(); s.iv = 1; s.sv = 2'b01; s.sn = 2'b01; s.srs = srcs(5, 0);
        s.memd = 5; s.memr = 1; cycle(s);
        s.exd = 5; s.exr = 1; cycle(s);
        s = idle(); repeat (3) cycle(s);

        // WAW on a variable-latency write until done.
        s = idle(); s.iv = 1; s.idst = 8; s.ilat = 0; cycle(s);
        s.ilat = 2; repeat (3) cycle(s);
        s.dv = 1; s.ddst = 8; cycle(s);
        s.dv = 0; cycle(s);
        s = idle(); repeat (3) cycle(s);

        // Done and re-issue on the same edge: issue wins.
        s = idle(); s.iv = 1; s.idst = 9; s.ilat = 5; cycle(s);
        s.dv = 1; s.ddst = 9; s.ilat = 2; cycle(s);
        s = idle(); s.iv = 1; s.sv = 2'b01; s.sn = 2'b01; s.srs = srcs(9, 0);
        repeat (4) cycle(s);

        // Register 0 and want-only ports never stall.
        s = idle(); s.iv = 1; s.sv = 2'b01; s.sn = 2'b01; s.srs = srcs(0, 0);
        s.exd = 0; s.exr = 1; cycle(s);
        s = idle(); s.iv = 1; s.idst = 4; s.ilat = 6; cycle(s);
        s = idle(); s.iv = 1; s.sv = 2'b10; s.sn = 2'b00; s.srs = srcs(0, 4);
        s.exd = 7; s.exr = 1; repeat (2) cycle(s);

        // Reset discards in-flight entries; done right after is ignored.
        s = idle(); s.iv = 1; s.idst = 10; cycle(s);
        s.idst = 11; cycle(s);
        s.idst = 12; cycle(s);
        s = idle(); cycle(s);
        s.rst = 1; cycle(s);
        s = idle(); s.dv = 1; s.ddst = 10; s.iv = 1; s.sv = 2'b01; s.sn = 2'b01;
        s.srs = srcs(10, 0); cycle(s);
        s.dv = 0; cycle(s);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int k = 0; k < 3000; k++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 99) == 0);
            s.iv   = ($urandom_range(0, 3) != 0);
            s.idst = RW'($urandom_range(0, 7));
            s.ilat = ($urandom_range(0, 4) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 6));
            s.dv   = ($urandom_range(0, 5) == 0);
            s.ddst = RW'($urandom_range(0, 7));
            s.sv   = NSRC'($urandom_range(0, 3));
            s.sn   = NSRC'($urandom_range(0, 3));
            s.srs  = srcs(RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)));
            s.exd  = RW'($urandom_range(0, 7));
            s.memd = RW'($urandom_range(0, 7));
            s.wbd  = RW'($urandom_range(0, 7));
            s.exr  = ($urandom_range(0, 2) == 0);
            s.memr = ($urandom_range(0, 2) == 0);
            s.wbr  = ($urandom_range(0, 2) == 0);
            cycle(s);
        end

        s = idle(); repeat (4) cycle(s);
        repeat (3) @(negedge clk);
        chk("queue_drain", cyc, 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
